// File: rtl/histogram_readout.sv
// Streams a completed 256-bin histogram out of a sync RAM as (bin, count, CDF) beats,
// then sweeps the RAM clear strobe once and pulses done.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for iStart; the start cycle itself issues read 0
// READ  | issuing addresses while skid buffer + in-flight has room
// DRAIN | all addresses issued; emptying buffer until last beat taken
// CLEAR | oClearRam high for BINS cycles (down-counter to zero)
// DONE  | one-cycle oDone; accumulator and indices rearmed
module histogram_readout #(
    parameter int BINS  = 256,
    parameter int CNT_W = 20,
    parameter int CDF_W = 28
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    output logic [7:0]       oRdAddr,
    input  logic [CNT_W-1:0] iRdData,
    output logic             oValid,
    input  logic             iReady,
    output logic [7:0]       oBin,
    output logic [CNT_W-1:0] oCount,
    output logic [CDF_W-1:0] oCdf,
    output logic             oLast,
    output logic             oClearRam,
    output logic             oBusy,
    output logic             oDone
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_CLEAR, S_DONE} state_t;

    typedef struct packed {
        logic [7:0]       bin;
        logic [CNT_W-1:0] cnt;
        logic [CDF_W-1:0] cdf;
        logic             last;
    } beat_t;

    localparam logic [8:0] LAST_IDX = 9'(BINS - 1);

    state_t           state_q, state_d;
    logic [8:0]       addr_q, addr_d;
    logic [8:0]       cap_q, cap_d;
    logic [8:0]       clr_q, clr_d;
    logic [CDF_W-1:0] acc_q, acc_d;
    logic             inflight_q, inflight_d;
    beat_t            ent0_q, ent0_d, ent1_q, ent1_d;
    logic             v0_q, v0_d, v1_q, v1_d;

    logic             pop;
    logic             can_read;
    logic             issue;
    logic [1:0]       occ_after;
    beat_t            cap_beat;

    assign pop = v0_q && iReady;

    // Room is judged after this cycle's acceptance so a free-flowing stream sustains one beat per cycle.
    assign occ_after = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, inflight_q} - {1'b0, pop};
    assign can_read  = ((state_q == S_IDLE) && iStart) || (state_q == S_READ);
    assign issue     = can_read && (occ_after < 2'd2);

    always_comb begin
        cap_beat      = '0;
        cap_beat.bin  = cap_q[7:0];
        cap_beat.cnt  = iRdData;
        cap_beat.cdf  = acc_q + CDF_W'(iRdData);
        cap_beat.last = (cap_q == LAST_IDX);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cap_d      = cap_q;
        clr_d      = clr_q;
        acc_d      = acc_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        inflight_d = issue;

        if (pop) begin
            ent0_d = ent1_q;
            v0_d   = v1_q;
            v1_d   = 1'b0;
        end
        if (inflight_q) begin
            if (!v0_d) begin
                ent0_d = cap_beat;
                v0_d   = 1'b1;
            end else begin
                ent1_d = cap_beat;
                v1_d   = 1'b1;
            end
            acc_d = cap_beat.cdf;
            cap_d = cap_q + 9'd1;
        end
        if (issue) begin
            addr_d = addr_q + 9'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (iStart) state_d = S_READ;
            end
            S_READ: begin
                if (issue && (addr_q == LAST_IDX)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && ent0_q.last) begin
                    state_d = S_CLEAR;
                    clr_d   = LAST_IDX;
                end
            end
            S_CLEAR: begin
                if (clr_q == 9'd0) state_d = S_DONE;
                else               clr_d   = clr_q - 9'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                acc_d   = '0;
                cap_d   = '0;
                addr_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cap_q      <= '0;
            clr_q      <= '0;
            acc_q      <= '0;
            inflight_q <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cap_q      <= cap_d;
            clr_q      <= clr_d;
            acc_q      <= acc_d;
            inflight_q <= inflight_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
        end
    end

    assign oRdAddr   = (state_q == S_READ) ? addr_q[7:0] : 8'd0;
    assign oValid    = v0_q;
    assign oBin      = ent0_q.bin;
    assign oCount    = ent0_q.cnt;
    assign oCdf      = ent0_q.cdf;
    assign oLast     = v0_q && ent0_q.last;
    assign oClearRam = (state_q == S_CLEAR);
    assign oBusy     = (state_q != S_IDLE);
    assign oDone     = (state_q == S_DONE);

endmodule

// File: tb/tb_histogram_readout.sv
// Directed bench for histogram_readout: sync RAM model, stream order/CDF, stalls,
// clear sweep timing, ignored starts and mid-run reset.
module tb_histogram_readout;

    localparam int BINS  = 256;
    localparam int CNT_W = 20;
    localparam int CDF_W = 28;

    logic             iClk = 1'b0;
    logic             iRst_n;
    logic             iStart;
    logic [7:0]       oRdAddr;
    logic [CNT_W-1:0] iRdData;
    logic             oValid;
    logic             iReady;
    logic [7:0]       oBin;
    logic [CNT_W-1:0] oCount;
    logic [CDF_W-1:0] oCdf;
    logic             oLast;
    logic             oClearRam;
    logic             oBusy;
    logic             oDone;

    logic [CNT_W-1:0] mem [BINS];

    int n_checks = 0;
    int n_fail   = 0;

    histogram_readout #(.BINS(BINS), .CNT_W(CNT_W), .CDF_W(CDF_W)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .oRdAddr(oRdAddr),
        .iRdData(iRdData), .oValid(oValid), .iReady(iReady), .oBin(oBin),
        .oCount(oCount), .oCdf(oCdf), .oLast(oLast), .oClearRam(oClearRam),
        .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) iRdData <= mem[oRdAddr];

    function automatic logic [CDF_W-1:0] tri_cdf(input int k);
        return CDF_W'((k * (k + 1)) / 2);
    endfunction

    task automatic load_ramp();
        for (int k = 0; k < BINS; k++) mem[k] = CNT_W'(k);
    endtask

    task automatic start_run();
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int cyc;
        cyc = 0;
        while (oBusy === 1'b1 && cyc < 1000) begin
            @(negedge iClk);
            cyc++;
        end
        ok = (oBusy === 1'b0);
    endtask

    task automatic test_reset();
        iRst_n = 1'b0; iStart = 1'b0; iReady = 1'b0;
        load_ramp();
        repeat (3) @(negedge iClk);
        n_checks++;
        if ({oRdAddr, oValid, oBin, oCount, oCdf, oLast, oClearRam, oBusy, oDone} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got addr=%0d valid=%b bin=%0d cnt=%0d cdf=%0d last=%b clr=%b busy=%b done=%b exp all zero",
                     oRdAddr, oValid, oBin, oCount, oCdf, oLast, oClearRam, oBusy, oDone);
        end
        iRst_n = 1'b1;
        @(negedge iClk);
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b exp 0", oBusy);
        end
    endtask

    task automatic test_ramp();
        logic [CDF_W-1:0] last_cdf;
        bit ok;
        last_cdf = '0;
        load_ramp();
        iReady = 1'b1;
        start_run();
        n_checks++;
        if (oValid !== 1'b0 || oBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_latency1 got valid=%b busy=%b exp valid=0 busy=1", oValid, oBusy);
        end
        @(negedge iClk);
        for (int k = 0; k < BINS; k++) begin
            n_checks++;
            if ({oValid, oBin, oCount, oCdf, oLast} !== {1'b1, 8'(k), CNT_W'(k), tri_cdf(k), (k == BINS - 1)}) begin
                n_fail++;
                $display("FAIL ramp_beat k=%0d got valid=%b bin=%0d cnt=%0d cdf=%0d last=%b exp cdf=%0d",
                         k, oValid, oBin, oCount, oCdf, oLast, tri_cdf(k));
            end
            if (k == BINS - 1) last_cdf = oCdf;
            @(negedge iClk);
        end
        n_checks++;
        if (last_cdf !== 28'd32640) begin
            n_fail++;
            $display("FAIL ramp_final_cdf got %0d exp 32640", last_cdf);
        end
        n_checks++;
        if (oValid !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_no_extra_beat got valid=%b exp 0", oValid);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ramp_idle_timeout got busy=%b exp 0", oBusy);
        end
    endtask

    task automatic test_full_scale();
        logic [CDF_W-1:0] last_cdf;
        bit ok;
        last_cdf = '0;
        for (int k = 0; k < BINS; k++) mem[k] = 20'hFFFFF;
        iReady = 1'b1;
        start_run();
        @(negedge iClk);
        for (int k = 0; k < BINS; k++) begin
            n_checks++;
            if ({oValid, oCount, oCdf} !== {1'b1, 20'hFFFFF, CDF_W'((k + 1) * 1048575)}) begin
                n_fail++;
                $display("FAIL full_beat k=%0d got valid=%b cnt=%0d cdf=%0d exp cdf=%0d",
                         k, oValid, oCount, oCdf, (k + 1) * 1048575);
            end
            if (k == BINS - 1) last_cdf = oCdf;
            @(negedge iClk);
        end
        n_checks++;
        if (last_cdf !== 28'd268435200) begin
            n_fail++;
            $display("FAIL full_final_cdf got %0d exp 268435200", last_cdf);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_idle_timeout got busy=%b exp 0", oBusy);
        end
    endtask

    task automatic test_random_ready();
        int k, cyc;
        bit stalled, ok;
        logic [57:0] snap;
        k = 0; cyc = 0; stalled = 1'b0; snap = '0;
        load_ramp();
        iReady = 1'b0;
        start_run();
        while (k < BINS && cyc < 3000) begin
            if (stalled) begin
                n_checks++;
                if ({oValid, oBin, oCount, oCdf, oLast} !== snap) begin
                    n_fail++;
                    $display("FAIL stall_hold k=%0d got valid=%b bin=%0d cdf=%0d exp held bin=%0d cdf=%0d",
                             k, oValid, oBin, oCdf, snap[56:49], snap[28:1]);
                end
            end
            if (oValid) begin
                n_checks++;
                if ({oBin, oCount, oCdf, oLast} !== {8'(k), CNT_W'(k), tri_cdf(k), (k == BINS - 1)}) begin
                    n_fail++;
                    $display("FAIL rand_beat k=%0d got bin=%0d cnt=%0d cdf=%0d last=%b exp cdf=%0d",
                             k, oBin, oCount, oCdf, oLast, tri_cdf(k));
                end
            end
            iReady  = ($urandom_range(0, 1) == 1);
            stalled = oValid && !iReady;
            snap    = {oValid, oBin, oCount, oCdf, oLast};
            if (oValid && iReady) k++;
            cyc++;
            @(negedge iClk);
        end
        n_checks++;
        if (k != BINS || oValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_beat_count got beats=%0d valid_after=%b exp beats=%0d valid_after=0", k, oValid, BINS);
        end
        iReady = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rand_idle_timeout got busy=%b exp 0", oBusy);
        end
    endtask

    task automatic test_clear_done();
        int cyc, n_clr, bad_side;
        bit ok;
        cyc = 0; n_clr = 0; bad_side = 0;
        load_ramp();
        iReady = 1'b1;
        start_run();
        while (!(oValid === 1'b1 && oLast === 1'b1) && cyc < 600) begin
            @(negedge iClk);
            cyc++;
        end
        @(negedge iClk);
        while (oClearRam === 1'b1 && n_clr < 600) begin
            n_clr++;
            if (oValid !== 1'b0 || oRdAddr !== 8'd0 || oDone !== 1'b0 || oBusy !== 1'b1) bad_side++;
            @(negedge iClk);
        end
        n_checks++;
        if (n_clr != BINS) begin
            n_fail++;
            $display("FAIL clear_length got %0d cycles exp %0d", n_clr, BINS);
        end
        n_checks++;
        if (bad_side != 0) begin
            n_fail++;
            $display("FAIL clear_side_outputs got %0d bad cycles exp 0", bad_side);
        end
        n_checks++;
        if (oDone !== 1'b1 || oClearRam !== 1'b0 || oBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse got done=%b clr=%b busy=%b exp done=1 clr=0 busy=1", oDone, oClearRam, oBusy);
        end
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        n_checks++;
        if (oDone !== 1'b0 || oBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_then_idle got done=%b busy=%b exp done=0 busy=0", oDone, oBusy);
        end
        start_run();
        n_checks++;
        if (oBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_after_done got busy=%b exp 1", oBusy);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL clear_idle_timeout got busy=%b exp 0", oBusy);
        end
    endtask

    task automatic test_start_ignored();
        int cyc, beats, n_clr, n_done;
        cyc = 0; beats = 0; n_clr = 0; n_done = 0;
        load_ramp();
        iReady = 1'b1;
        start_run();
        while (oBusy === 1'b1 && cyc < 1500) begin
            iStart = 1'b0;
            if (oValid) begin
                n_checks++;
                if (oBin !== 8'(beats)) begin
                    n_fail++;
                    $display("FAIL ignore_beat_order got bin=%0d exp %0d", oBin, beats);
                end
                beats++;
                if (beats == 51) iStart = 1'b1;
            end
            if (oClearRam) begin
                n_clr++;
                if (n_clr == 100) iStart = 1'b1;
            end
            if (oDone) n_done++;
            cyc++;
            @(negedge iClk);
        end
        iStart = 1'b0;
        n_checks++;
        if (beats != BINS || n_clr != BINS || n_done != 1) begin
            n_fail++;
            $display("FAIL ignore_single_run got beats=%0d clr=%0d done=%0d exp %0d/%0d/1", beats, n_clr, n_done, BINS, BINS);
        end
        repeat (5) @(negedge iClk);
        n_checks++;
        if (oBusy !== 1'b0 || oValid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_rerun got busy=%b valid=%b exp 0/0", oBusy, oValid);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        bit ok;
        cyc = 0;
        load_ramp();
        iReady = 1'b1;
        start_run();
        while (!(oValid === 1'b1 && oBin === 8'd100) && cyc < 400) begin
            @(negedge iClk);
            cyc++;
        end
        n_checks++;
        if (oBin !== 8'd100 || oCdf !== tri_cdf(100)) begin
            n_fail++;
            $display("FAIL midrun_reach_100 got bin=%0d cdf=%0d exp 100/%0d", oBin, oCdf, tri_cdf(100));
        end
        iRst_n = 1'b0;
        #1;
        n_checks++;
        if ({oRdAddr, oValid, oBin, oCount, oCdf, oLast, oClearRam, oBusy, oDone} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset_zero got addr=%0d valid=%b bin=%0d cnt=%0d cdf=%0d busy=%b exp all zero",
                     oRdAddr, oValid, oBin, oCount, oCdf, oBusy);
        end
        @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);
        start_run();
        @(negedge iClk);
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ({oValid, oBin, oCount, oCdf} !== {1'b1, 8'(k), CNT_W'(k), tri_cdf(k)}) begin
                n_fail++;
                $display("FAIL restart_beat k=%0d got valid=%b bin=%0d cnt=%0d cdf=%0d exp cdf=%0d",
                         k, oValid, oBin, oCount, oCdf, tri_cdf(k));
            end
            @(negedge iClk);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL restart_idle_timeout got busy=%b exp 0", oBusy);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_full_scale();
        test_random_ready();
        test_clear_done();
        test_start_ignored();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion exp finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
